// File: rtl/output_writeback_unit.sv
// ---------------------------------------------------------------------------
// output_writeback_unit
//
// Purpose:
//   This block sits at the consumer end of the address-generator result
//   interface of the 4-lane matrix-vector multiplier. It does the following:
//   - Captures the four MAC results and their four destination addresses
//     when `valid` is high.
//   - On the next `write` strobe, replays the captured lanes as four
//     single-port writes into the output buffer, in lane order 1..4.
//   - Counts the rows written (+4 per block) and raises a sticky `done`
//     once all N rows are stored.
//   - Raises a sticky `overrun` when the generator violates the protocol.
//
// Handshake:
//   `valid` qualifies the results and addresses during the cycle it is high.
//   `write` is a single-cycle commit strobe. It is honoured only after a
//   block has been captured, which is the ARMED state. There is no ready
//   signal back to the generator. Instead, the generator spaces its blocks
//   so that the four-cycle WRITE phase always finishes before the next
//   `valid` arrives. Any `valid` or `write` that breaks this spacing is
//   ignored and recorded in `overrun`.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   valid, write                    generator handshake (see above)
//   out_1_address..out_4_address    per-lane destination addresses
//   mac_1_result..mac_4_result      per-lane accumulator results
//   buf_we, buf_address, buf_data   registered output-buffer write port
//   busy                            high while ARMED or WRITE
//   done                            sticky, all N rows written
//   overrun                         sticky, protocol violation seen
//   fsm_state                       current FSM state, for observation
// ---------------------------------------------------------------------------
module output_writeback_unit #(
    parameter int N                         = 8,
    parameter int ACC_WIDTH                 = 20,
    parameter int INPUT_BUFFER_ADDRESS_BITS = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid,
    input  logic                                 write,
    input  logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_1_address,
    input  logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_2_address,
    input  logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_3_address,
    input  logic [INPUT_BUFFER_ADDRESS_BITS-1:0] out_4_address,
    input  logic [ACC_WIDTH-1:0]                 mac_1_result,
    input  logic [ACC_WIDTH-1:0]                 mac_2_result,
    input  logic [ACC_WIDTH-1:0]                 mac_3_result,
    input  logic [ACC_WIDTH-1:0]                 mac_4_result,
    output logic                                 buf_we,
    output logic [INPUT_BUFFER_ADDRESS_BITS-1:0] buf_address,
    output logic [ACC_WIDTH-1:0]                 buf_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun,
    output logic [1:0]                           fsm_state
);

    localparam int AW = INPUT_BUFFER_ADDRESS_BITS;

    // The row counter is one bit wider than an address, so it can hold N.
    localparam logic [AW:0] ROWS_TOTAL     = (AW + 1)'(N);
    localparam logic [AW:0] ROWS_PER_BLOCK = (AW + 1)'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           lane_q, lane_d;
    logic [AW:0]          rows_q, rows_d;
    logic [AW-1:0]        cap_addr_q [4];
    logic [AW-1:0]        cap_addr_d [4];
    logic [ACC_WIDTH-1:0] cap_data_q [4];
    logic [ACC_WIDTH-1:0] cap_data_d [4];
    logic                 buf_we_q, buf_we_d;
    logic [AW-1:0]        buf_address_q, buf_address_d;
    logic [ACC_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    // Gather the lane inputs into arrays so the capture can use a loop.
    logic [AW-1:0]        in_addr [4];
    logic [ACC_WIDTH-1:0] in_data [4];

    always_comb begin
        in_addr[0] = out_1_address;
        in_addr[1] = out_2_address;
        in_addr[2] = out_3_address;
        in_addr[3] = out_4_address;
        in_data[0] = mac_1_result;
        in_data[1] = mac_2_result;
        in_data[2] = mac_3_result;
        in_data[3] = mac_4_result;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        rows_d        = rows_q;
        cap_addr_d    = cap_addr_q;
        cap_data_d    = cap_data_q;
        buf_we_d      = 1'b0;
        buf_address_d = buf_address_q;
        buf_data_d    = buf_data_q;
        overrun_d     = overrun_q;

        unique case (state_q)
            IDLE: begin
                // A stray write strobe in IDLE is silently ignored.
                if (valid) begin
                    if (done_q) begin
                        // A valid after the final block is a violation.
                        overrun_d = 1'b1;
                    end else begin
                        cap_addr_d = in_addr;
                        cap_data_d = in_data;
                        state_d    = ARMED;
                    end
                end
            end

            ARMED: begin
                // A second valid re-captures the block (the latest one wins)
                // and is flagged. When write arrives in the same cycle, the
                // WRITE phase reads the registers captured at this edge.
                if (valid) begin
                    cap_addr_d = in_addr;
                    cap_data_d = in_data;
                    overrun_d  = 1'b1;
                end
                if (write) begin
                    lane_d  = 2'd0;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                buf_we_d      = 1'b1;
                buf_address_d = cap_addr_q[lane_q];
                buf_data_d    = cap_data_q[lane_q];
                if (valid || write) begin
                    overrun_d = 1'b1;
                end
                if (lane_q == 2'd3) begin
                    rows_d  = rows_q + ROWS_PER_BLOCK;
                    state_d = IDLE;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ARMED) || (state_d == WRITE);

        // The row count settles at the edge that issues the last write,
        // so done rises one cycle after that write.
        done_d = done_q || (rows_q == ROWS_TOTAL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lane_q        <= 2'd0;
            rows_q        <= '0;
            buf_we_q      <= 1'b0;
            buf_address_q <= '0;
            buf_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cap_addr_q[i] <= '0;
                cap_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            rows_q        <= rows_d;
            buf_we_q      <= buf_we_d;
            buf_address_q <= buf_address_d;
            buf_data_q    <= buf_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
            for (int i = 0; i < 4; i++) begin
                cap_addr_q[i] <= cap_addr_d[i];
                cap_data_q[i] <= cap_data_d[i];
            end
        end
    end

    assign buf_we      = buf_we_q;
    assign buf_address = buf_address_q;
    assign buf_data    = buf_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign fsm_state   = state_q;

endmodule
